// File: rtl/obstacle_scheduler.sv
// Frame-paced obstacle spawner: LFSR lane pick, level-scaled gaps, pause/blocked handling.
// Latency: spawn pulse 2 clocks after the expiring tick; waits in BLOCKED while all lanes are busy.
module obstacle_scheduler #(
  parameter int unsigned INIT_GAP  = 120,
  parameter int unsigned GAP_STEP  = 8,
  parameter int unsigned GAP_FLOOR = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_start,
  input  logic        i_restart,
  input  logic        i_is_finished,
  input  logic        i_is_dead,
  input  logic [2:0]  i_lane_busy,
  output logic [2:0]  o_spawn,
  output logic [2:0]  o_state,
  output logic [3:0]  o_level,
  output logic [15:0] o_spawn_count,
  output logic        o_active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_PICK    = 3'd2,
    S_SPAWN   = 3'd3,
    S_BLOCKED = 3'd4
  } state_t;

  state_t      state_q;
  logic [9:0]  gap_q;
  logic [15:0] lfsr_q;
  logic [2:0]  spawn_q;
  logic [3:0]  level_q;
  logic [15:0] count_q;
  logic        active_q;

  logic        paused;
  logic [15:0] lfsr_d;
  logic [1:0]  cand, c1, c2, pick;
  logic        pick_vld;
  logic [15:0] dec;
  logic [9:0]  base;
  logic [9:0]  reload_d;
  logic [15:0] count_d;

  always_comb begin
    paused = i_is_finished | i_is_dead;
    lfsr_d = lfsr_q;
    if (i_frame_tick && !paused && state_q != S_IDLE)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Lane search order: cand, cand+1, cand+2 (mod 3).
    cand = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
    c1   = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    pick_vld = 1'b1;
    pick     = cand;
    if (!i_lane_busy[cand])    pick = cand;
    else if (!i_lane_busy[c1]) pick = c1;
    else if (!i_lane_busy[c2]) pick = c2;
    else                       pick_vld = 1'b0;

    // Clamp before subtracting so the base gap never underflows.
    dec = 16'(level_q) * 16'(GAP_STEP);
    if (dec + 16'(GAP_FLOOR) >= 16'(INIT_GAP)) base = 10'(GAP_FLOOR);
    else                                      base = 10'(16'(INIT_GAP) - dec);
    reload_d = base + {6'd0, lfsr_q[3:0]};
    count_d  = count_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      spawn_q  <= '0;
      level_q  <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (i_restart) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      spawn_q  <= '0;
      level_q  <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      spawn_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            gap_q    <= 10'(INIT_GAP);
            state_q  <= S_COUNT;
            active_q <= 1'b1;
          end
        end
        S_COUNT: begin
          if (i_frame_tick && !paused) begin
            if (gap_q <= 10'd1) begin
              gap_q   <= '0;
              state_q <= S_PICK;
            end else begin
              gap_q <= gap_q - 10'd1;
            end
          end
        end
        S_PICK: begin
          if (pick_vld) begin
            spawn_q <= 3'b001 << pick;
            state_q <= S_SPAWN;
          end else begin
            state_q <= S_BLOCKED;
          end
        end
        S_SPAWN: begin
          count_q <= count_d;
          if (count_d[2:0] == 3'd0 && level_q != 4'd15)
            level_q <= level_q + 4'd1;
          gap_q   <= reload_d;
          state_q <= S_COUNT;
        end
        S_BLOCKED: begin
          if (!(&i_lane_busy) && !paused)
            state_q <= S_PICK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_spawn       = spawn_q;
  assign o_state       = state_q;
  assign o_level       = level_q;
  assign o_spawn_count = count_q;
  assign o_active      = active_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a small LFSR/gap/level reference model.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, tick, start, restart, fin, dead;
  logic [2:0]  busy;
  logic [2:0]  o_spawn, o_state;
  logic [3:0]  o_level;
  logic [15:0] o_spawn_count;
  logic        o_active;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int          m_count, m_level, m_gap, m_gap_lvl;

  obstacle_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_start(start),
    .i_restart(restart), .i_is_finished(fin), .i_is_dead(dead),
    .i_lane_busy(busy), .o_spawn(o_spawn), .o_state(o_state),
    .o_level(o_level), .o_spawn_count(o_spawn_count), .o_active(o_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [2:0] pick_oh(input logic [15:0] s, input logic [2:0] b);
    int c;
    int l;
    c = (s[1:0] == 2'd3) ? 0 : int'(s[1:0]);
    for (int k = 0; k < 3; k++) begin
      l = (c + k) % 3;
      if (!b[l]) return 3'b001 << l;
    end
    return 3'b000;
  endfunction

  function automatic int reload(input int lvl, input logic [15:0] s);
    int b;
    b = 120 - lvl * 8;
    if (b < 40) b = 40;
    return b + int'(s[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_count = 0; m_level = 0; m_gap = 120; m_gap_lvl = 0;
  endtask

  task automatic model_spawn();
    m_count   = (m_count + 1) % 65536;
    m_gap     = reload(m_level, m_lfsr);
    m_gap_lvl = m_level;
    if (m_count % 8 == 0 && m_level < 15) m_level++;
  endtask

  task automatic run_to_pick(output int n);
    n = 0;
    do begin
      tick1();
      n++;
      m_lfsr = lfsr_nx(m_lfsr);
    end while (o_state !== 3'd2 && n < 400);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 0; start = 0; restart = 0; fin = 0; dead = 0; busy = 3'b000;
    model_reset();
    step(); step();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
    checks++; if (o_spawn !== 3'd0) begin errors++; $display("FAIL reset_spawn: got %b want 000", o_spawn); end
    checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", o_level); end
    checks++; if (o_spawn_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_spawn_count); end
    checks++; if (o_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", o_active); end
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_stay_idle: got %0d want 0", o_state); end
  endtask

  task automatic test_first_spawn();
    int n;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", o_state); end
    checks++; if (o_active !== 1'b1) begin errors++; $display("FAIL start_active: got %b want 1", o_active); end
    run_to_pick(n);
    checks++; if (n != 120) begin errors++; $display("FAIL first_gap: got %0d ticks want 120", n); end
    checks++; if (o_spawn !== 3'd0) begin errors++; $display("FAIL first_pick_spawn: got %b want 000", o_spawn); end
    step();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL first_spawn_state: got %0d want 3", o_state); end
    checks++; if (o_spawn !== pick_oh(m_lfsr, busy)) begin errors++; $display("FAIL first_spawn_lane: got %b want %b", o_spawn, pick_oh(m_lfsr, busy)); end
    model_spawn();
    step();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL first_back_count: got %0d want 1", o_state); end
    checks++; if (o_spawn_count !== 16'(m_count)) begin errors++; $display("FAIL first_count: got %0d want %0d", o_spawn_count, m_count); end
    checks++; if (o_spawn !== 3'd0) begin errors++; $display("FAIL first_spawn_clear: got %b want 000", o_spawn); end
  endtask

  task automatic test_blocked();
    int n;
    busy = 3'b111;
    run_to_pick(n);
    checks++; if (n != m_gap) begin errors++; $display("FAIL blk_gap: got %0d want %0d", n, m_gap); end
    step();
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL blk_state: got %0d want 4", o_state); end
    checks++; if (o_spawn !== 3'd0) begin errors++; $display("FAIL blk_spawn: got %b want 000", o_spawn); end
    step(); step();
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL blk_hold: got %0d want 4", o_state); end
    busy = 3'b011;
    step();
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL blk_repick: got %0d want 2", o_state); end
    step();
    checks++; if (o_spawn !== 3'b100) begin errors++; $display("FAIL blk_release_lane: got %b want 100", o_spawn); end
    model_spawn();
    busy = 3'b000;
    step();
    checks++; if (o_spawn_count !== 16'(m_count)) begin errors++; $display("FAIL blk_count: got %0d want %0d", o_spawn_count, m_count); end
  endtask

  task automatic test_pause();
    int n;
    for (int i = 0; i < 10; i++) begin tick1(); m_lfsr = lfsr_nx(m_lfsr); end
    dead = 1'b1;
    for (int i = 0; i < 50; i++) tick1();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL pause_hold_state: got %0d want 1", o_state); end
    dead = 1'b0;
    run_to_pick(n);
    checks++; if (n != m_gap - 10) begin errors++; $display("FAIL pause_resume_gap: got %0d want %0d", n, m_gap - 10); end
    dead = 1'b1;
    step();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL pause_spawn_state: got %0d want 3", o_state); end
    checks++; if (o_spawn !== pick_oh(m_lfsr, 3'b000)) begin errors++; $display("FAIL pause_spawn_lane: got %b want %b", o_spawn, pick_oh(m_lfsr, 3'b000)); end
    model_spawn();
    step();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL pause_park: got %0d want 1", o_state); end
    checks++; if (o_spawn_count !== 16'(m_count)) begin errors++; $display("FAIL pause_count: got %0d want %0d", o_spawn_count, m_count); end
    dead = 1'b0;
  endtask

  task automatic test_levels();
    int n;
    while (m_count < 128) begin
      run_to_pick(n);
      checks++; if (n != m_gap) begin errors++; $display("FAIL lvl_gap: spawn %0d got %0d want %0d", m_count + 1, n, m_gap); end
      if (m_gap_lvl >= 10) begin
        checks++; if (n < 40 || n > 55) begin errors++; $display("FAIL lvl_gap_range: got %0d want 40..55", n); end
      end
      step();
      checks++; if (o_spawn !== pick_oh(m_lfsr, 3'b000)) begin errors++; $display("FAIL lvl_lane: got %b want %b", o_spawn, pick_oh(m_lfsr, 3'b000)); end
      model_spawn();
      step();
      checks++; if (o_level !== 4'(m_level) || o_spawn_count !== 16'(m_count)) begin
        errors++; $display("FAIL lvl_level_count: got %0d/%0d want %0d/%0d", o_level, o_spawn_count, m_level, m_count);
      end
    end
    checks++; if (o_level !== 4'd15) begin errors++; $display("FAIL lvl_saturate: got %0d want 15", o_level); end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 30; i++) tick1();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL arst_state: got %0d want 0", o_state); end
    checks++; if (o_level !== 4'd0 || o_spawn_count !== 16'd0) begin errors++; $display("FAIL arst_counters: got %0d/%0d want 0/0", o_level, o_spawn_count); end
    checks++; if (o_active !== 1'b0 || o_spawn !== 3'd0) begin errors++; $display("FAIL arst_active_spawn: got %b/%b want 0/000", o_active, o_spawn); end
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL arst_idle: got %0d want 0", o_state); end
    model_reset();
    start = 1'b1; step(); start = 1'b0;
    run_to_pick(n);
    checks++; if (n != 120) begin errors++; $display("FAIL arst_full_gap: got %0d want 120", n); end
    step();
    checks++; if (o_spawn !== pick_oh(m_lfsr, 3'b000)) begin errors++; $display("FAIL arst_lane: got %b want %b", o_spawn, pick_oh(m_lfsr, 3'b000)); end
    model_spawn();
    step();
    checks++; if (o_spawn_count !== 16'd1) begin errors++; $display("FAIL arst_count: got %0d want 1", o_spawn_count); end
  endtask

  task automatic test_restart();
    int n;
    run_to_pick(n);
    checks++; if (n != m_gap) begin errors++; $display("FAIL rst_gap: got %0d want %0d", n, m_gap); end
    step();
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL rst_in_spawn: got %0d want 3", o_state); end
    restart = 1'b1; step(); restart = 1'b0;
    checks++; if (o_state !== 3'd0 || o_spawn !== 3'd0) begin errors++; $display("FAIL rst_abort: got state %0d spawn %b want 0/000", o_state, o_spawn); end
    checks++; if (o_spawn_count !== 16'd0 || o_level !== 4'd0 || o_active !== 1'b0) begin
      errors++; $display("FAIL rst_clear: got %0d/%0d/%b want 0/0/0", o_spawn_count, o_level, o_active);
    end
    restart = 1'b1; start = 1'b1; step(); restart = 1'b0; start = 1'b0;
    checks++; if (o_state !== 3'd0 || o_active !== 1'b0) begin errors++; $display("FAIL rst_over_start: got %0d/%b want 0/0", o_state, o_active); end
    model_reset();
    start = 1'b1; step(); start = 1'b0;
    run_to_pick(n);
    checks++; if (n != 120) begin errors++; $display("FAIL rst_full_gap: got %0d want 120", n); end
    step();
    checks++; if (o_spawn !== pick_oh(m_lfsr, 3'b000)) begin errors++; $display("FAIL rst_seed_lane: got %b want %b", o_spawn, pick_oh(m_lfsr, 3'b000)); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_blocked();
    test_pause();
    test_levels();
    test_async_reset();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The block SHALL have parameter INIT_GAP, default 120, giving the frames from start to first spawn and the level-0 base gap.
REQ-002 The block SHALL have parameter GAP_STEP, default 8, giving the frames removed from the base gap per level.
REQ-003 The block SHALL have parameter GAP_FLOOR, default 40, giving the minimum base gap in frames.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the LFSR reset value.
REQ-005 The block SHALL have these ports (one clock; reset is asynchronous and active-low):
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_frame_tick, input, 1: one-clock pulse per frame (synchronized v_sync rise).
- i_start, input, 1: begin scheduling.
- i_restart, input, 1: synchronous clear to reset state.
- i_is_finished, input, 1: game finished, pause.
- i_is_dead, input, 1: player dead, pause.
- i_lane_busy, input, 3: obstacle lane k still in flight.
- o_spawn, output, 3: one-hot, one-clock spawn command to lane k.
- o_state, output, 3: FSM state (IDLE=0, COUNT=1, PICK=2, SPAWN=3, BLOCKED=4).
- o_level, output, 4: difficulty level.
- o_spawn_count, output, 16: total spawns.
- o_active, output, 1: state != IDLE.

Function
REQ-006 All state and outputs SHALL be registered, with no combinational input-to-output path.
REQ-007 lfsr SHALL be a 16-bit Fibonacci LFSR with taps 16,14,13,11 (new bit = b15^b13^b12^b10, shift left) that advances one step on each unpaused i_frame_tick in any state except IDLE.
REQ-008 In IDLE, i_start=1 SHALL load gap_cnt=INIT_GAP (10-bit) and move to COUNT; i_start in any other state SHALL be ignored.
REQ-009 In COUNT, each unpaused i_frame_tick SHALL decrement gap_cnt; a tick with gap_cnt==1 SHALL set gap_cnt=0 and move to PICK.
REQ-010 PICK SHALL last exactly one clock and form cand = (lfsr[1:0]==3) ? 0 : lfsr[1:0].
REQ-011 PICK SHALL select the first non-busy lane in the order cand, (cand+1) mod 3, (cand+2) mod 3, latch it and move to SPAWN.
REQ-012 If all of i_lane_busy are set in PICK, the FSM SHALL move to BLOCKED.
REQ-013 SPAWN SHALL last exactly one clock, during which:
- o_spawn is one-hot on the latched lane.
- o_spawn_count increments, wrapping 16'hFFFF to 0.
- gap_cnt reloads.
- the FSM returns to COUNT.
REQ-014 o_spawn SHALL be 3'b000 in every state other than SPAWN.
REQ-015 o_level SHALL increment (saturating at 15) in the SPAWN cycle whose post-increment o_spawn_count[2:0]==0, i.e. every 8 spawns.
REQ-016 The reload value SHALL be max(INIT_GAP - o_level*GAP_STEP, GAP_FLOOR) + lfsr[3:0], computed unsigned with no underflow.
REQ-017 This reload SHALL use the o_level value before any increment made in the same SPAWN cycle.
REQ-018 In BLOCKED, when any lane is free (~&i_lane_busy) and the block is unpaused, the FSM SHALL move to PICK on the next clock without waiting for a tick.
REQ-019 Pause (i_is_finished | i_is_dead) SHALL freeze COUNT and BLOCKED: gap_cnt, lfsr and state hold, and ticks are ignored.
REQ-020 PICK and SPAWN SHALL always complete even if pause is asserted mid-sequence; the FSM then parks in COUNT.
REQ-021 Leaving pause SHALL resume counting from the held gap_cnt with no lost or extra decrement.
REQ-022 An i_frame_tick coincident with a state transition SHALL be consumed only by COUNT; a tick arriving during PICK, SPAWN or BLOCKED SHALL neither decrement gap_cnt nor be queued.

Reset
REQ-023 i_rst_n=0 SHALL asynchronously set:
- state to IDLE.
- o_spawn, o_level, o_spawn_count, gap_cnt and o_active to 0.
- lfsr to LFSR_SEED.
REQ-024 i_restart=1 SHALL apply the same values synchronously, override every other input (including simultaneous i_start) and abort any state, including SPAWN, with o_spawn forced to 0 in the following cycle.
REQ-025 Reset deassertion SHALL take effect on the next i_clk rising edge, and the FSM SHALL leave IDLE only on a subsequent i_start.

Verification
REQ-026 Reset, i_start, 120 unpaused ticks, lanes free -> o_spawn is one-hot exactly 2 clocks after the 120th tick, on the lane given by the LFSR model; o_spawn_count=1; o_state returns to 1.
REQ-027 i_lane_busy=3'b111 at PICK -> o_state=4 and no o_spawn; release lane 2 only -> o_spawn=3'b100 exactly 2 clocks after the release.
REQ-028 i_is_dead=1 for 50 ticks mid-COUNT -> gap_cnt and lfsr unchanged; after release the spawn arrives exactly 50 ticks later than the unpaused reference.
REQ-029 Run 128 spawns -> o_level steps every 8 spawns to 15 and holds; the reload base reaches GAP_FLOOR=40 at level 10 (120-80), and gap is always in [40,55] from then on.
REQ-030 i_restart asserted in the SPAWN cycle, or together with i_start in IDLE -> next cycle o_state=0, o_spawn=0, counters 0, lfsr=16'hACE1.
REQ-031 Assert i_rst_n=0 asynchronously mid-COUNT with no clock edge -> outputs clear immediately; one extra i_start after release restarts a full 120-tick gap.
